// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter with burst tracking and locked-transfer support.
// Grants, owner index and lock qualifier are all registered.
module ahb_arbiter #(
    parameter int NO_OF_MASTERS   = 2,
    parameter int DEFAULT_MASTER  = 0,
    parameter int MASTER_ID_WIDTH = (NO_OF_MASTERS > 1) ? $clog2(NO_OF_MASTERS) : 1
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    input  logic [NO_OF_MASTERS-1:0]   HBUSREQ,
    input  logic [NO_OF_MASTERS-1:0]   HLOCK,
    input  logic [1:0]                 HTRANS,
    input  logic [2:0]                 HBURST,
    input  logic                       HREADY,
    output logic [NO_OF_MASTERS-1:0]   HGRANT,
    output logic [MASTER_ID_WIDTH-1:0] HMASTER,
    output logic                       HMASTLOCK
);

    localparam int N  = NO_OF_MASTERS;
    localparam int IW = MASTER_ID_WIDTH;
    localparam logic [N-1:0]  ONE_HOT0  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]  DEF_GRANT = ONE_HOT0 << DEFAULT_MASTER;
    localparam logic [IW-1:0] DEF_ID    = IW'(DEFAULT_MASTER);

    localparam logic [1:0] T_IDLE   = 2'd0;
    localparam logic [1:0] T_BUSY   = 2'd1;
    localparam logic [1:0] T_NONSEQ = 2'd2;
    localparam logic [1:0] T_SEQ    = 2'd3;

    logic [N-1:0]  r_grant;
    logic [IW-1:0] r_master;
    logic          r_mastlock;
    logic [3:0]    r_beats;
    logic [IW-1:0] r_rr_last;

    logic [4:0]    w_len;
    logic [4:0]    w_rem;
    logic [IW-1:0] w_g;
    logic [IW-1:0] w_winner;
    logic          w_found;
    logic          w_lock_hold;
    logic          w_arb_ok;

    always_comb begin
        case (HBURST)
            3'd2, 3'd3: w_len = 5'd4;
            3'd4, 3'd5: w_len = 5'd8;
            3'd6, 3'd7: w_len = 5'd16;
            default:    w_len = 5'd1;
        endcase
    end

    // Beats still owed by the current burst, including the one on the bus now.
    always_comb begin
        case (HTRANS)
            T_NONSEQ: w_rem = w_len;
            T_SEQ:    w_rem = {1'b0, r_beats};
            T_BUSY:   w_rem = {1'b0, r_beats} + 5'd1;
            default:  w_rem = 5'd0;
        endcase
    end

    always_comb begin
        w_g = '0;
        for (int i = 0; i < N; i++) begin
            if (r_grant[i]) w_g = IW'(i);
        end
    end

    always_comb begin
        w_winner = DEF_ID;
        w_found  = 1'b0;
        for (int i = 1; i <= N; i++) begin
            int idx;
            idx = (int'(r_rr_last) + i) % N;
            if (!w_found && HBUSREQ[idx]) begin
                w_found  = 1'b1;
                w_winner = IW'(idx);
            end
        end
    end

    assign w_lock_hold = |(r_grant & HLOCK & HBUSREQ);
    assign w_arb_ok    = HREADY & ~w_lock_hold & (w_rem <= 5'd1);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_grant    <= DEF_GRANT;
            r_master   <= DEF_ID;
            r_mastlock <= 1'b0;
            r_beats    <= 4'd0;
            r_rr_last  <= DEF_ID;
        end else if (HREADY) begin
            case (HTRANS)
                T_NONSEQ: r_beats <= w_len[3:0] - 4'd1;
                T_SEQ:    r_beats <= (r_beats != 4'd0) ? r_beats - 4'd1 : 4'd0;
                T_IDLE:   r_beats <= 4'd0;
                default:  r_beats <= r_beats;
            endcase
            r_master   <= w_g;
            r_mastlock <= |(r_grant & HLOCK);
            if (w_arb_ok) begin
                r_grant   <= ONE_HOT0 << w_winner;
                r_rr_last <= w_winner;
            end
        end
    end

    assign HGRANT    = r_grant;
    assign HMASTER   = r_master;
    assign HMASTLOCK = r_mastlock;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Bench for ahb_arbiter (4 masters): vector table, directed burst/lock/reset
// sequences and random traffic against a behavioural model.
module tb_ahb_arbiter;

    logic       HCLK;
    logic       HRESETn;
    logic [3:0] hbusreq;
    logic [3:0] hlock;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;
    logic [3:0] HGRANT;
    logic [1:0] HMASTER;
    logic       HMASTLOCK;

    ahb_arbiter #(
        .NO_OF_MASTERS(4),
        .DEFAULT_MASTER(0)
    ) dut (
        .HCLK(HCLK),
        .HRESETn(HRESETn),
        .HBUSREQ(hbusreq),
        .HLOCK(hlock),
        .HTRANS(htrans),
        .HBURST(hburst),
        .HREADY(hready),
        .HGRANT(HGRANT),
        .HMASTER(HMASTER),
        .HMASTLOCK(HMASTLOCK)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model state: grantee index, last winner, owner, lock, beats owed.
    int m_grant, m_last, m_owner, m_mlock, m_beats;
    int lens[8] = '{1, 1, 4, 4, 8, 8, 16, 16};

    typedef struct {
        logic [3:0] req;
        logic [3:0] lck;
        logic [1:0] tr;
        logic [2:0] bu;
        logic       rdy;
        logic [3:0] eg;
        logic [1:0] em;
        logic       el;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic model_reset();
        m_grant = 0;
        m_last  = 0;
        m_owner = 0;
        m_mlock = 0;
        m_beats = 0;
    endtask

    task automatic tick();
        int len, rem, g, w;
        bit ok;
        g   = m_grant;
        len = lens[hburst];
        case (htrans)
            2'd2:    rem = len;
            2'd3:    rem = m_beats;
            2'd1:    rem = m_beats + 1;
            default: rem = 0;
        endcase
        ok = hready && !(hlock[g] && hbusreq[g]) && rem <= 1;
        w = 0;
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (m_last + 1 + k) % 4;
            if (hbusreq[c]) begin
                w = c;
                break;
            end
        end
        @(posedge HCLK);
        #1;
        if (hready) begin
            case (htrans)
                2'd2: m_beats = len - 1;
                2'd3: m_beats = (m_beats > 0) ? m_beats - 1 : 0;
                2'd0: m_beats = 0;
                default: ;
            endcase
            m_owner = g;
            m_mlock = hlock[g];
            if (ok) begin
                m_grant = w;
                m_last  = w;
            end
        end
        chk("model_grant", int'(HGRANT), 1 << m_grant);
        chk("model_master", int'(HMASTER), m_owner);
        chk("model_mastlock", int'(HMASTLOCK), m_mlock);
        chk("grant_onehot", int'($onehot(HGRANT)), 1);
    endtask

    task automatic set_in(input logic [3:0] r, input logic [3:0] l,
                          input logic [1:0] t, input logic [2:0] b,
                          input logic rd);
        hbusreq = r;
        hlock   = l;
        htrans  = t;
        hburst  = b;
        hready  = rd;
    endtask

    task automatic do_reset();
        @(negedge HCLK);
        set_in(4'b0, 4'b0, 2'd0, 3'd0, 1'b1);
        HRESETn = 1'b0;
        model_reset();
        #2;
        HRESETn = 1'b1;
    endtask

    task automatic run_incr8(input int wait_beat, input int wait_n,
                             input int exp_edges, input string tag);
        int edges;
        do_reset();
        edges = 0;
        for (int beat = 1; beat <= 8; beat++) begin
            set_in((beat >= 2) ? 4'b0011 : 4'b0001, 4'b0,
                   (beat == 1) ? 2'd2 : 2'd3, 3'd5, 1'b1);
            if (beat == wait_beat) begin
                hready = 1'b0;
                for (int w = 0; w < wait_n; w++) begin
                    tick();
                    edges++;
                    chk({tag, "_wait_hold"}, int'(HGRANT), 1);
                end
                hready = 1'b1;
            end
            tick();
            edges++;
            if (HGRANT != 4'b0001) break;
        end
        chk({tag, "_handover_edge"}, edges, exp_edges);
        chk({tag, "_grant_m1"}, int'(HGRANT), 2);
        chk({tag, "_master_still_m0"}, int'(HMASTER), 0);
        set_in(4'b0010, 4'b0, 2'd2, 3'd0, 1'b1);
        tick();
        chk({tag, "_master_m1"}, int'(HMASTER), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{4'b1111, 4'b0, 2'd2, 3'd0, 1'b1, 4'b0010, 2'd0, 1'b0};
        vt[1] = '{4'b1111, 4'b0, 2'd2, 3'd0, 1'b1, 4'b0100, 2'd1, 1'b0};
        vt[2] = '{4'b1111, 4'b0, 2'd2, 3'd0, 1'b1, 4'b1000, 2'd2, 1'b0};
        vt[3] = '{4'b1111, 4'b0, 2'd2, 3'd0, 1'b1, 4'b0001, 2'd3, 1'b0};
        vt[4] = '{4'b1111, 4'b0, 2'd2, 3'd0, 1'b1, 4'b0010, 2'd0, 1'b0};
        vt[5] = '{4'b1111, 4'b0, 2'd2, 3'd0, 1'b1, 4'b0100, 2'd1, 1'b0};
        vt[6] = '{4'b0000, 4'b0, 2'd0, 3'd0, 1'b1, 4'b0001, 2'd2, 1'b0};
        vt[7] = '{4'b0000, 4'b0, 2'd0, 3'd0, 1'b1, 4'b0001, 2'd0, 1'b0};
        vt[8] = '{4'b0100, 4'b0, 2'd0, 3'd0, 1'b0, 4'b0001, 2'd0, 1'b0};
        vt[9] = '{4'b0100, 4'b0, 2'd0, 3'd0, 1'b1, 4'b0100, 2'd0, 1'b0};

        set_in(4'b0, 4'b0, 2'd0, 3'd0, 1'b1);
        HRESETn = 1'b0;
        model_reset();
        #12;
        chk("reset_grant", int'(HGRANT), 1);
        chk("reset_master", int'(HMASTER), 0);
        chk("reset_mastlock", int'(HMASTLOCK), 0);
        HRESETn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_grant", int'(HGRANT), 1);
            chk("idle_master", int'(HMASTER), 0);
        end

        for (int i = 0; i < 10; i++) begin
            set_in(vt[i].req, vt[i].lck, vt[i].tr, vt[i].bu, vt[i].rdy);
            tick();
            chk($sformatf("vec%0d_grant", i), int'(HGRANT), int'(vt[i].eg));
            chk($sformatf("vec%0d_master", i), int'(HMASTER), int'(vt[i].em));
            chk($sformatf("vec%0d_lock", i), int'(HMASTLOCK), int'(vt[i].el));
        end

        run_incr8(0, 0, 8, "incr8");
        run_incr8(5, 3, 11, "incr8_wait");

        // Locked sequence: M1 takes the bus and holds it through IDLE cycles.
        do_reset();
        set_in(4'b0010, 4'b0, 2'd0, 3'd0, 1'b1);
        tick();
        chk("lock_pre_grant", int'(HGRANT), 2);
        for (int i = 0; i < 8; i++) begin
            set_in(4'b0011, 4'b0010, (i < 6) ? 2'd2 : 2'd0, 3'd0, 1'b1);
            tick();
            chk("lock_hold_grant", int'(HGRANT), 2);
            chk("lock_mastlock", int'(HMASTLOCK), 1);
        end
        set_in(4'b0011, 4'b0000, 2'd0, 3'd0, 1'b1);
        tick();
        chk("unlock_grant_m0", int'(HGRANT), 1);
        chk("unlock_mastlock", int'(HMASTLOCK), 0);
        tick();
        chk("unlock_master_m0", int'(HMASTER), 0);

        // Async reset in the middle of an INCR16 owned by M1.
        do_reset();
        set_in(4'b0010, 4'b0, 2'd0, 3'd0, 1'b1);
        tick();
        for (int beat = 1; beat <= 6; beat++) begin
            set_in(4'b0011, 4'b0, (beat == 1) ? 2'd2 : 2'd3, 3'd7, 1'b1);
            tick();
            chk("incr16_hold", int'(HGRANT), 2);
        end
        chk("incr16_owner", int'(HMASTER), 1);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("async_rst_grant", int'(HGRANT), 1);
        chk("async_rst_master", int'(HMASTER), 0);
        chk("async_rst_lock", int'(HMASTLOCK), 0);
        model_reset();
        #1;
        HRESETn = 1'b1;
        hbusreq = 4'b0011;
        tick();
        chk("post_rst_rearb", int'(HGRANT), 2);

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            set_in(4'($urandom), 4'($urandom & $urandom & $urandom),
                   2'($urandom), 3'($urandom), ($urandom % 4) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
